// File: rtl/pkt_gen_pkg.sv
// Shared types and constants for the packet stream generator: run states,
// data-mode encodings, header magic and Galois LFSR tap masks.
package pkt_gen_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MODE_COUNT     = 2'd0,
        MODE_CONST     = 2'd1,
        MODE_LFSR      = 2'd2,
        MODE_COUNT_ALT = 2'd3
    } mode_t;

    localparam logic [7:0] HDR_MAGIC = 8'hA5;

    // Right-shifting Galois masks: polynomial term x^e sets bit e-1.
    function automatic logic [63:0] lfsr_taps(input int width);
        case (width)
            16:      return 64'h0000_0000_0000_B400;
            24:      return 64'h0000_0000_00E1_0000;
            32:      return 64'h0000_0000_8020_0003;
            64:      return 64'hD800_0000_0000_0000;
            default: return (64'd1 << (width - 1)) | 64'd1;
        endcase
    endfunction

endpackage

// File: rtl/pkt_gen_lfsr.sv
// Galois LFSR; value is the word the next payload capture emits, so a load
// stores the seed already advanced by one step (a zero seed becomes 1).
module pkt_gen_lfsr
    import pkt_gen_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             step,
    output logic [WIDTH-1:0] value
);

    localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] s);
        return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
    endfunction

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            value <= advance((seed == '0) ? WIDTH'(1) : seed);
        end else if (step) begin
            value <= advance(value);
        end
    end

endmodule

// File: rtl/pkt_stream_gen.sv
// Real-time test-stream source: fixed-length packets at a programmable sample
// rate with backpressure drop counting. Define PKT_GEN_HDR_EN for header words.
module pkt_stream_gen
    import pkt_gen_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DIV_W  = 16,
    parameter int LEN_W  = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic [31:0]       cfg_pkt_limit,
    input  logic [1:0]        cfg_mode,
    input  logic [DATA_W-1:0] cfg_pattern,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    output logic              m_last,
    input  logic              m_ready,
    output logic              busy,
    output logic [31:0]       pkt_count,
    output logic [31:0]       drop_count
);

    state_t            state;
    mode_t             mode_r;
    logic [DIV_W-1:0]  div_r, div_cnt;
    logic [LEN_W-1:0]  len_r, word_idx;
    logic [31:0]       limit_r, pkt_cap;
    logic [DATA_W-1:0] pattern_r, cnt_val, lfsr_val;

    logic active, tick, want, accept, slot_free, capture, drop, last_word;
    logic hdr_word, pay_step, limit_hit, end_req, done, launch;
    logic [DATA_W-1:0] payload, word;

    always_comb begin
        active    = (state != IDLE);
        launch    = (state == IDLE) && start;
        tick      = active && (div_cnt == div_r - DIV_W'(1));
        // In DRAIN only the unfinished packet may still capture words.
        want      = tick && ((state == RUN) || (word_idx != '0));
        accept    = m_valid && m_ready;
        slot_free = !m_valid || m_ready;
        capture   = want && slot_free;
        drop      = want && !slot_free;
        last_word = (word_idx == len_r - LEN_W'(1));
        pay_step  = capture && !hdr_word;
        limit_hit = capture && last_word && (limit_r != '0) && (pkt_cap + 32'd1 == limit_r);
        end_req   = (state == RUN) && (stop || limit_hit);
        done      = !capture && (word_idx == '0) && slot_free;
        // NOTE: the case carries a default so payload is assigned on every path
        // and no latch is inferred.
        case (mode_r)
            MODE_CONST: payload = pattern_r;
            MODE_LFSR:  payload = lfsr_val;
            default:    payload = cnt_val;
        endcase
    end

`ifdef PKT_GEN_HDR_EN
    logic [DATA_W-9:0] pkt_seq;

    assign hdr_word = (word_idx == '0);
    assign word     = hdr_word ? {HDR_MAGIC, pkt_seq} : payload;

    always_ff @(posedge clk) begin
        if (rst || launch) begin
            pkt_seq <= '0;
        end else if (capture && hdr_word) begin
            pkt_seq <= pkt_seq + (DATA_W-8)'(1);
        end
    end
`else
    assign hdr_word = 1'b0;
    assign word     = payload;
`endif

    pkt_gen_lfsr #(.WIDTH(DATA_W)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (launch),
        .seed  (cfg_pattern),
        .step  (pay_step),
        .value (lfsr_val)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            m_valid    <= 1'b0;
            m_last     <= 1'b0;
            m_data     <= '0;
            pkt_count  <= '0;
            drop_count <= '0;
            div_cnt    <= '0;
            word_idx   <= '0;
            cnt_val    <= '0;
            pkt_cap    <= '0;
            div_r      <= DIV_W'(1);
            len_r      <= LEN_W'(1);
            limit_r    <= '0;
            mode_r     <= MODE_COUNT;
            pattern_r  <= '0;
        end else begin
            busy <= active;
            if (active) div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);

            if (capture) begin
                m_valid  <= 1'b1;
                m_data   <= word;
                m_last   <= last_word;
                word_idx <= last_word ? '0 : word_idx + LEN_W'(1);
            end else if (accept) begin
                m_valid <= 1'b0;
            end

            if (pay_step) cnt_val <= cnt_val + DATA_W'(1);
            if (capture && last_word) pkt_cap <= pkt_cap + 32'd1;
            if (accept && m_last && pkt_count != '1) pkt_count <= pkt_count + 32'd1;
            if (drop && drop_count != '1) drop_count <= drop_count + 32'd1;

            // Later assignments below override the per-cycle updates above.
            case (state)
                IDLE: if (start) begin
                    state      <= RUN;
                    div_r      <= (cfg_div == '0) ? DIV_W'(1) : cfg_div;
                    len_r      <= (cfg_len == '0) ? LEN_W'(1) : cfg_len;
                    limit_r    <= cfg_pkt_limit;
                    mode_r     <= mode_t'(cfg_mode);
                    pattern_r  <= cfg_pattern;
                    div_cnt    <= '0;
                    word_idx   <= '0;
                    cnt_val    <= '0;
                    pkt_cap    <= '0;
                    pkt_count  <= '0;
                    drop_count <= '0;
                end
                RUN:     if (end_req) state <= done ? IDLE : DRAIN;
                DRAIN:   if (done) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_stream_gen.sv
// Self-checking bench for pkt_stream_gen: directed scenarios plus randomized
// runs compared against a packet-level reference model of the stream.
module tb_pkt_stream_gen;

    localparam int DATA_W = 32;
    localparam int DIV_W  = 16;
    localparam int LEN_W  = 11;
`ifdef PKT_GEN_HDR_EN
    localparam bit HDR = 1'b1;
`else
    localparam bit HDR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic [DIV_W-1:0]  cfg_div = '0;
    logic [LEN_W-1:0]  cfg_len = '0;
    logic [31:0]       cfg_pkt_limit = '0;
    logic [1:0]        cfg_mode = '0;
    logic [DATA_W-1:0] cfg_pattern = '0;
    logic [DATA_W-1:0] m_data;
    logic              m_valid, m_last;
    logic              m_ready = 1'b1;
    logic              busy;
    logic [31:0]       pkt_count, drop_count;

    pkt_stream_gen #(.DATA_W(DATA_W), .DIV_W(DIV_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .cfg_div(cfg_div), .cfg_len(cfg_len), .cfg_pkt_limit(cfg_pkt_limit),
        .cfg_mode(cfg_mode), .cfg_pattern(cfg_pattern),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
        .busy(busy), .pkt_count(pkt_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
        int                t;
    } beat_t;

    beat_t got_q[$];
    beat_t exp_q[$];

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Monitor: outputs and m_ready are stable at the falling edge, so a
    // handshake seen here is the one the next rising edge completes.
    logic              hold_prev = 1'b0;
    logic              hold_last;
    logic [DATA_W-1:0] hold_data;
    always @(negedge clk) begin
        if (hold_prev) check("held_word_stable", {m_valid, m_last, m_data}, {1'b1, hold_last, hold_data});
        hold_prev = m_valid && !m_ready && !rst;
        hold_data = m_data;
        hold_last = m_last;
        if (m_valid && m_ready && !rst) got_q.push_back('{m_data, m_last, cyc});
    end

    // Reference LFSR from x^32+x^22+x^2+x+1, right-shifting Galois form.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        logic [31:0] poly;
        poly = (32'd1 << 31) | (32'd1 << 21) | (32'd1 << 1) | 32'd1;
        return s[0] ? ((s >> 1) ^ poly) : (s >> 1);
    endfunction

    task automatic build_expected(input int len, input int limit, input int mode, input logic [31:0] pattern);
        int          l;
        logic [31:0] lfsr;
        logic [31:0] count;
        beat_t       b;
        l     = (len == 0) ? 1 : len;
        lfsr  = (pattern == 32'd0) ? 32'd1 : pattern;
        count = 32'd0;
        exp_q.delete();
        for (int p = 0; p < limit; p++) begin
            for (int i = 0; i < l; i++) begin
                b.last = (i == l - 1);
                b.t    = 0;
                if (HDR && i == 0) begin
                    b.data = {8'hA5, 24'(p)};
                end else begin
                    lfsr = lfsr_next(lfsr);
                    case (mode)
                        1:       b.data = pattern;
                        2:       b.data = lfsr;
                        default: b.data = count;
                    endcase
                    count++;
                end
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic compare_stream(input string tag);
        int e0;
        check({tag, "_word_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            e0 = errors;
            check($sformatf("%s_data[%0d]", tag, i), got_q[i].data, exp_q[i].data);
            check($sformatf("%s_last[%0d]", tag, i), got_q[i].last, exp_q[i].last);
            if (errors != e0) break;
        end
    endtask

    // Start edge E0 is the second rising edge; returns at E0 + 1 time unit.
    task automatic launch(input int div, input int len, input logic [31:0] limit,
                          input int mode, input logic [31:0] pattern);
        cfg_div       = DIV_W'(div);
        cfg_len       = LEN_W'(len);
        cfg_pkt_limit = limit;
        cfg_mode      = 2'(mode);
        cfg_pattern   = pattern;
        got_q.delete();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_idle(input bit rnd, input int budget);
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            if (rnd) m_ready = ($urandom_range(0, 3) != 0);
            n++;
        end while (busy !== 1'b0 && n < budget);
        m_ready = 1'b1;
        check("idle_within_budget", n < budget, 1'b1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_word(input int idx, input int budget);
        int n;
        n = 0;
        while (!(m_valid && got_q.size() == idx) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check("word_seen_within_budget", n < budget, 1'b1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed no completion, expected summary before 3 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          lat;
        int          bad;
        int          first;
        int          div, len, limit, mode;
        logic [31:0] pat;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_last", m_last, 1'b0);
        check("rst_m_data", m_data, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_pkt_count", pkt_count, '0);
        check("rst_drop_count", drop_count, '0);
        rst = 1'b0;

        // stop in IDLE is ignored
        @(posedge clk); #1 stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("idle_stop_busy", busy, 1'b0);
        check("idle_stop_valid", m_valid, 1'b0);

        // Counter mode, div=50, len=100, limit=2
        build_expected(100, 2, 0, 32'd0);
        launch(50, 100, 2, 0, 32'd0);
        lat = 0;
        while (!m_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check("t1_first_word_latency", lat, 50);
        check("t1_busy_in_run", busy, 1'b1);
        wait_idle(1'b0, 20000);
        compare_stream("t1");
        bad = 0;
        for (int i = 1; i < got_q.size(); i++) if (got_q[i].t - got_q[i-1].t != 50) bad++;
        check("t1_spacing_errors", bad, 0);
        check("t1_pkt_count", pkt_count, 2);
        check("t1_drop_count", drop_count, 0);
        check("t1_busy_after", busy, 1'b0);

        // Backpressure: ready low for 10 edges while word 3 is held
        build_expected(8, 1, 0, 32'd0);
        launch(2, 8, 1, 0, 32'd0);
        wait_word(3, 200);
        m_ready = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("t2_held_valid", m_valid, 1'b1);
        check("t2_held_data", m_data, exp_q[3].data);
        m_ready = 1'b1;
        wait_idle(1'b0, 500);
        compare_stream("t2");
        check("t2_drop_count", drop_count, 5);
        check("t2_pkt_count", pkt_count, 1);

        // stop at word 3 of len=10, unlimited
        build_expected(10, 1, 0, 32'd0);
        launch(3, 10, 0, 0, 32'd0);
        wait_word(3, 200);
        stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        wait_idle(1'b0, 500);
        compare_stream("t3");
        check("t3_pkt_count", pkt_count, 1);
        check("t3_busy_after", busy, 1'b0);

        // Restart clears counters and data; a start mid-run is ignored
        launch(3, 10, 1, 0, 32'd0);
        check("t3r_pkt_count_cleared", pkt_count, 0);
        check("t3r_drop_count_cleared", drop_count, 0);
        repeat (7) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_idle(1'b0, 500);
        compare_stream("t3r");
        check("t3r_pkt_count", pkt_count, 1);

        // LFSR mode, seed 0, 1000 words back to back
        build_expected(50, 20, 2, 32'd0);
        launch(1, 50, 20, 2, 32'd0);
        wait_idle(1'b0, 5000);
        compare_stream("t4");
        first = HDR ? 1 : 0;
        if (got_q.size() > first) check("t4_first_payload", got_q[first].data, 32'h8020_0003);
        check("t4_pkt_count", pkt_count, 20);

        // Reset mid-packet with a word held and drops accumulated
        launch(2, 8, 0, 0, 32'd0);
        wait_word(11, 300);
        m_ready = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("t5_drops_before_rst", drop_count != 0, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("t5_rst_valid", m_valid, 1'b0);
        check("t5_rst_busy", busy, 1'b0);
        check("t5_rst_pkt_count", pkt_count, 0);
        check("t5_rst_drop_count", drop_count, 0);
        rst = 1'b0;
        m_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("t5_no_resume", m_valid, 1'b0);

        // Randomized configurations with random backpressure
        for (int it = 0; it < 8; it++) begin
            div   = $urandom_range(0, 4);
            len   = $urandom_range(0, 6);
            limit = $urandom_range(1, 3);
            mode  = $urandom_range(0, 3);
            pat   = (it == 2) ? 32'd0 : $urandom;
            build_expected(len, limit, mode, pat);
            launch(div, len, 32'(limit), mode, pat);
            wait_idle(1'b1, 4000);
            compare_stream($sformatf("rnd%0d", it));
            check($sformatf("rnd%0d_pkt_count", it), pkt_count, limit);
            check($sformatf("rnd%0d_busy_after", it), busy, 1'b0);
        end

`ifdef PKT_GEN_HDR_EN
        // Header words: len=4, limit=3
        build_expected(4, 3, 0, 32'd0);
        launch(1, 4, 3, 0, 32'd0);
        wait_idle(1'b0, 200);
        compare_stream("hdr");
        if (got_q.size() >= 12) begin
            check("hdr_0", got_q[0].data, 32'hA500_0000);
            check("hdr_1", got_q[4].data, 32'hA500_0001);
            check("hdr_2", got_q[8].data, 32'hA500_0002);
            check("hdr_payload_last", got_q[11].data, 32'd8);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
